// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff_out = x - y - z, borrow_out set when the
// subtraction needs to borrow from the next bit. Purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic diff_out,
  output logic borrow_out
);

  // Difference is the parity of the three inputs; borrow when y + z exceeds x.
  always_comb begin
    diff_out   = x ^ y ^ z;
    borrow_out = (~x & y) | (~(x ^ y) & z);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per
// clock through a single full_subtractor cell. Start/done handshake; the
// result and final borrow are only updated at completion.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // A one-bit counter is kept even for WIDTH = 1 so the compare stays legal.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] a_sh_q,       a_sh_d;
  logic [WIDTH-1:0] b_sh_q,       b_sh_d;
  logic [WIDTH-1:0] res_sh_q,     res_sh_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             borrow_reg_q, borrow_reg_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic             fs_diff_s;
  logic             fs_borrow_s;
  logic [WIDTH-1:0] res_shift_s;

  full_subtractor u_fs (
    .x          (a_sh_q[0]),
    .y          (b_sh_q[0]),
    .z          (borrow_reg_q),
    .diff_out   (fs_diff_s),
    .borrow_out (fs_borrow_s)
  );

  // Result register after this cycle's bit enters at the MSB; written as a
  // shift plus top-bit overwrite so it also works when WIDTH = 1.
  always_comb begin
    res_shift_s            = res_sh_q >> 1'b1;
    res_shift_s[WIDTH-1]   = fs_diff_s;
  end

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    cnt_d        = cnt_q;
    borrow_reg_d = borrow_reg_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts start exactly like IDLE, enabling back-to-back runs.
        if (start) begin
          a_sh_d       = a;
          b_sh_d       = b;
          res_sh_d     = '0;
          borrow_reg_d = 1'b0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          state_d      = SHIFT;
        end else begin
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d       = a_sh_q >> 1'b1;
        b_sh_d       = b_sh_q >> 1'b1;
        res_sh_d     = res_shift_s;
        borrow_reg_d = fs_borrow_s;
        cnt_d        = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the full result and the final borrow together.
          diff_d       = res_shift_s;
          borrow_out_d = fs_borrow_s;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = DONE;
        end else begin
          busy_d       = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      cnt_q        <= '0;
      borrow_reg_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      cnt_q        <= cnt_d;
      borrow_reg_q <= borrow_reg_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor: an 8-bit instance for the
// handshake/latency/reset scenarios and a 3-bit instance swept exhaustively.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;

  logic       start3;
  logic [2:0] a3, b3;
  logic       busy3, done3, bo3;
  logic [2:0] diff3;

  int total_checks  = 0;
  int passed_checks = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 8-bit operation: start, count busy cycles until done, check result.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] exp_d, input logic exp_b);
    int busy_cnt;
    int changed;
    logic [7:0] prev_diff;
    prev_diff = diff8;
    busy_cnt  = 0;
    changed   = 0;
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    for (int i = 0; i < 20 && !done8; i++) begin
      if (busy8) busy_cnt++;
      if (diff8 !== prev_diff) changed++;
      tick();
    end
    check({tag, "_done_seen"}, {31'd0, done8}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, 32'd8);
    check({tag, "_no_early_diff"}, changed, 32'd0);
    check({tag, "_busy_at_done"}, {31'd0, busy8}, 32'd0);
    check({tag, "_diff"}, {24'd0, diff8}, {24'd0, exp_d});
    check({tag, "_borrow"}, {31'd0, bo8}, {31'd0, exp_b});
    tick();
    check({tag, "_done_pulse_1cyc"}, {31'd0, done8}, 32'd0);
    check({tag, "_diff_held"}, {24'd0, diff8}, {24'd0, exp_d});
  endtask

  // 3-bit operation against a bench-side reference of (a - b) mod 8.
  task automatic run3(input logic [2:0] av, input logic [2:0] bv);
    int busy_cnt;
    logic [3:0] ref_full;
    ref_full = {1'b0, av} - {1'b0, bv};
    busy_cnt = 0;
    a3 = av; b3 = bv; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 10 && !done3; i++) begin
      if (busy3) busy_cnt++;
      tick();
    end
    check($sformatf("w3_%0d_%0d_diff", av, bv), {29'd0, diff3}, {29'd0, ref_full[2:0]});
    check($sformatf("w3_%0d_%0d_borrow", av, bv), {31'd0, bo3}, {31'd0, (av < bv)});
    if (av == 3'd5 && bv == 3'd6)
      check("w3_busy_cycles", busy_cnt, 32'd3);
    tick();
  endtask

  initial begin
    int n;
    int ndone;
    logic [7:0] cap_d;
    logic       cap_b;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start3 = 1'b0; a3 = 3'd0;  b3 = 3'd0;
    tick(); tick();

    // Reset state
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_diff", {24'd0, diff8}, 32'd0);
    check("rst_borrow", {31'd0, bo8}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic operations
    run8("op_200_55", 8'd200, 8'd55, 8'h91, 1'b0);
    run8("op_55_200", 8'd55, 8'd200, 8'h6F, 1'b1);
    run8("op_0_1", 8'h00, 8'h01, 8'hFF, 1'b1);
    run8("op_a5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0);

    // Start while busy is ignored
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0; cap_d = 8'h00; cap_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        ndone++;
        cap_d = diff8;
        cap_b = bo8;
      end
      tick();
    end
    check("ign_done_count", ndone, 32'd1);
    check("ign_diff", {24'd0, cap_d}, 32'd7);
    check("ign_borrow", {31'd0, cap_b}, 32'd0);
    check("ign_idle_after", {31'd0, busy8}, 32'd0);

    // Back-to-back: second start in the DONE cycle
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 20 && !done8; i++) tick();
    check("b2b_first_done", {31'd0, done8}, 32'd1);
    check("b2b_first_diff", {24'd0, diff8}, 32'd5);
    check("b2b_first_borrow", {31'd0, bo8}, 32'd0);
    a8 = 8'd4; b8 = 8'd9; start8 = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (n == 1) begin
        start8 = 1'b0;
        check("b2b_busy_again", {31'd0, busy8}, 32'd1);
        check("b2b_done_dropped", {31'd0, done8}, 32'd0);
      end
      if (done8) break;
    end
    check("b2b_second_done", {31'd0, done8}, 32'd1);
    check("b2b_spacing", n, 32'd9);
    check("b2b_second_diff", {24'd0, diff8}, 32'hFB);
    check("b2b_second_borrow", {31'd0, bo8}, 32'd1);
    tick();

    // Reset mid-operation
    a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy8}, 32'd0);
    check("mrst_done", {31'd0, done8}, 32'd0);
    check("mrst_diff", {24'd0, diff8}, 32'd0);
    check("mrst_borrow", {31'd0, bo8}, 32'd0);
    ndone = 0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) ndone++;
      tick();
    end
    check("mrst_no_done", ndone, 32'd0);
    run8("op_3_3", 8'd3, 8'd3, 8'h00, 1'b0);

    // WIDTH = 3 exhaustive sweep
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        run3(ia[2:0], ib[2:0]);
      end
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per clock.
- Wraps a single full_subtractor cell: x = minuend bit, y = subtrahend bit, z = registered borrow.
- Sits directly downstream of the operand source. Trades WIDTH cycles of latency for one subtractor cell.
- Start/done handshake toward the controller.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy = 0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  a - b mod 2^WIDTH; held until next completion
- borrow_out  output  1  final borrow (1 iff a < b unsigned); held with diff

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - state = IDLE.
  - busy, done, diff, borrow_out, internal shift registers, bit counter and borrow register all 0.
  - A reset mid-operation discards the operation; no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at edge E0: load a_sh = a, b_sh = b, res_sh = 0, borrow_reg = 0, cnt = 0.
  - Go to SHIFT; busy = 1 from E0 onward.
- SHIFT, at each edge E1..EWIDTH:
  - full_subtractor inputs: x = a_sh[0], y = b_sh[0], z = borrow_reg.
  - res_sh = {diff_bit, res_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one.
  - borrow_reg = borrow_bit; cnt increments.
- Completion, at the edge where cnt == WIDTH-1:
  - diff = final res_sh value, including this bit.
  - borrow_out = this cycle's borrow_bit.
  - done = 1, busy = 0, state = DONE.
- Latency: busy is high for exactly WIDTH cycles. done is high in cycle WIDTH+1 counted from the start edge.
- DONE:
  - Lasts one cycle; done = 1, busy = 0.
  - start = 1 here is accepted exactly as in IDLE, giving back-to-back operation.
  - Otherwise return to IDLE; done = 0.
- start while busy = 1 is ignored. a and b may change freely after the start edge.
- diff and borrow_out change only at completion edges. They never show intermediate values.
- WIDTH = 1: single SHIFT cycle. cnt width = max(1, clog2(WIDTH)).

Decomposition:
- Package serial_sub_pkg: state encoding constants IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
- Sub-module: the team's existing full_subtractor (ports x, y, z, diff_out, borrow_out), instantiated once, purely combinational.
- Everything else stays in serial_subtractor.

Test Plan:
- WIDTH=8, a=200, b=55, start 1 cycle -> busy high 8 cycles, then done pulse 1 cycle with diff=145 (0x91), borrow_out=0.
- a=55, b=200 -> diff=0x6F (111), borrow_out=1. Separately a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Separately a=0xA5, b=0xA5 -> diff=0x00, borrow_out=0.
- Start a=10, b=3; pulse start with a=1, b=2 on cycle 3 of busy -> exactly one done, diff=7, borrow_out=0.
- Start a=9, b=4; assert start again in the DONE cycle with a=4, b=9 -> first done diff=5/borrow 0; second done exactly 9 cycles later with diff=0xFB/borrow 1.
- Start a=100, b=1; drop rst_n at cycle 4 -> busy, done, diff, borrow_out go to 0 immediately; no done pulse. After release, a=3, b=3 completes with diff=0.
- WIDTH=3, all 64 (a,b) pairs -> diff == (a-b) mod 8 and borrow_out == (a<b) for every pair, checked against the reference model.
